// File: rtl/pong_game_core.sv
// Pong engine: ball, player and AI paddles, scores and match FSM.
// Advances one game step every TICK_DIV frame ticks; all outputs are registered.
module pong_game_core #(
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned BALL_SIZE    = 10,
  parameter int unsigned PADDLE_W     = 10,
  parameter int unsigned PADDLE_H     = 60,
  parameter int unsigned OPP_X        = 30,
  parameter int unsigned PLAYER_X     = 600,
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned PADDLE_SPEED = 2,
  parameter int unsigned AI_SPEED     = 1,
  parameter int unsigned TICK_DIV     = 2,
  parameter int unsigned SERVE_DELAY  = 30,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_frame_tick,
  input  logic               i_btn_up,
  input  logic               i_btn_down,
  input  logic               i_serve,
  output logic [COORD_W-1:0] o_ball_x,
  output logic [COORD_W-1:0] o_ball_y,
  output logic [COORD_W-1:0] o_player_y,
  output logic [COORD_W-1:0] o_opp_y,
  output logic [SCORE_W-1:0] o_player_score,
  output logic [SCORE_W-1:0] o_opp_score,
  output logic [1:0]         o_state,
  output logic               o_point_pulse
);

  localparam int unsigned XW    = COORD_W + 1;
  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [XW-1:0] L_BALL_CX   = XW'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [XW-1:0] L_BALL_CY   = XW'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [XW-1:0] L_PAD_C     = XW'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [XW-1:0] L_PAD_MAX   = XW'(SCREEN_H - PADDLE_H);
  localparam logic [XW-1:0] L_BALL_MAXY = XW'(SCREEN_H - BALL_SIZE);
  localparam logic [XW-1:0] L_BS        = XW'(BALL_SIZE);
  localparam logic [XW-1:0] L_BS_HALF   = XW'(BALL_SIZE / 2);
  localparam logic [XW-1:0] L_PH        = XW'(PADDLE_H);
  localparam logic [XW-1:0] L_PH_HALF   = XW'(PADDLE_H / 2);
  localparam logic [XW-1:0] L_BSPD      = XW'(BALL_SPEED);
  localparam logic [XW-1:0] L_PSPD      = XW'(PADDLE_SPEED);
  localparam logic [XW-1:0] L_AISPD     = XW'(AI_SPEED);
  localparam logic [XW-1:0] L_OPP_EDGE  = XW'(OPP_X + PADDLE_W);
  localparam logic [XW-1:0] L_PLAYER_X  = XW'(PLAYER_X);
  localparam logic [XW-1:0] L_SCREEN_W  = XW'(SCREEN_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SERVE = 2'b01,
    S_PLAY  = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t             r_state;
  logic [COORD_W-1:0] r_ball_x;
  logic [COORD_W-1:0] r_ball_y;
  logic [COORD_W-1:0] r_player_y;
  logic [COORD_W-1:0] r_opp_y;
  logic [SCORE_W-1:0] r_player_score;
  logic [SCORE_W-1:0] r_opp_score;
  logic               r_dir_x;
  logic               r_dir_y;
  logic [DIV_W-1:0]   r_div;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_point_pulse;

  logic               w_step;
  logic [XW-1:0]      w_bx;
  logic [XW-1:0]      w_by;
  logic [XW-1:0]      w_py;
  logic [XW-1:0]      w_oy;
  logic [XW-1:0]      w_opp_c;
  logic [XW-1:0]      w_ball_c;
  logic [COORD_W-1:0] w_player_nxt;
  logic [COORD_W-1:0] w_opp_nxt;
  logic [COORD_W-1:0] w_bx_nxt;
  logic [COORD_W-1:0] w_by_nxt;
  logic               w_dir_x_nxt;
  logic               w_dir_y_nxt;
  logic               w_ov_opp;
  logic               w_ov_player;
  logic               w_miss_l;
  logic               w_miss_r;
  logic [SCORE_W-1:0] w_ps_inc;
  logic [SCORE_W-1:0] w_os_inc;

  assign w_step   = i_frame_tick && (r_div == DIV_W'(TICK_DIV - 1));
  assign w_bx     = {1'b0, r_ball_x};
  assign w_by     = {1'b0, r_ball_y};
  assign w_py     = {1'b0, r_player_y};
  assign w_oy     = {1'b0, r_opp_y};
  assign w_opp_c  = w_oy + L_PH_HALF;
  assign w_ball_c = w_by + L_BS_HALF;
  assign w_ps_inc = r_player_score + SCORE_W'(1);
  assign w_os_inc = r_opp_score + SCORE_W'(1);

  assign w_ov_opp    = (w_by + L_BS > w_oy) && (w_by < w_oy + L_PH);
  assign w_ov_player = (w_by + L_BS > w_py) && (w_by < w_py + L_PH);

  // Player paddle: up wins over down, clamped to the playfield
  always_comb begin
    w_player_nxt = r_player_y;
    if (i_btn_up) begin
      w_player_nxt = (w_py < L_PSPD) ? '0 : COORD_W'(w_py - L_PSPD);
    end else if (i_btn_down) begin
      w_player_nxt = (w_py + L_PSPD > L_PAD_MAX) ? COORD_W'(L_PAD_MAX)
                                                 : COORD_W'(w_py + L_PSPD);
    end
  end

  // AI paddle chases the ball centre with a dead band of AI_SPEED
  always_comb begin
    w_opp_nxt = r_opp_y;
    if (w_ball_c > w_opp_c + L_AISPD) begin
      w_opp_nxt = (w_oy + L_AISPD > L_PAD_MAX) ? COORD_W'(L_PAD_MAX)
                                                : COORD_W'(w_oy + L_AISPD);
    end else if (w_opp_c > w_ball_c + L_AISPD) begin
      w_opp_nxt = (w_oy < L_AISPD) ? '0 : COORD_W'(w_oy - L_AISPD);
    end
  end

  // Ball vertical motion with wall clamp and reflection (dir 1 = down)
  always_comb begin
    w_by_nxt    = r_ball_y;
    w_dir_y_nxt = r_dir_y;
    if (!r_dir_y) begin
      if (w_by < L_BSPD) begin
        w_by_nxt    = '0;
        w_dir_y_nxt = 1'b1;
      end else begin
        w_by_nxt = COORD_W'(w_by - L_BSPD);
      end
    end else if (w_by + L_BSPD > L_BALL_MAXY) begin
      w_by_nxt    = COORD_W'(L_BALL_MAXY);
      w_dir_y_nxt = 1'b0;
    end else begin
      w_by_nxt = COORD_W'(w_by + L_BSPD);
    end
  end

  // Ball horizontal motion: paddle bounce takes precedence over a miss (dir 1 = right)
  always_comb begin
    w_bx_nxt    = r_ball_x;
    w_dir_x_nxt = r_dir_x;
    w_miss_l    = 1'b0;
    w_miss_r    = 1'b0;
    if (!r_dir_x) begin
      if (w_bx >= L_OPP_EDGE && w_bx <= L_OPP_EDGE + L_BSPD && w_ov_opp) begin
        w_bx_nxt    = COORD_W'(L_OPP_EDGE);
        w_dir_x_nxt = 1'b1;
      end else if (w_bx < L_BSPD) begin
        w_miss_l = 1'b1;
      end else begin
        w_bx_nxt = COORD_W'(w_bx - L_BSPD);
      end
    end else begin
      if (w_bx + L_BS <= L_PLAYER_X && w_bx + L_BS + L_BSPD >= L_PLAYER_X && w_ov_player) begin
        w_bx_nxt    = COORD_W'(L_PLAYER_X - L_BS);
        w_dir_x_nxt = 1'b0;
      end else if (w_bx + L_BS + L_BSPD > L_SCREEN_W) begin
        w_miss_r = 1'b1;
      end else begin
        w_bx_nxt = COORD_W'(w_bx + L_BSPD);
      end
    end
  end

  // Match FSM and all game state; nothing changes outside a step
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_ball_x       <= COORD_W'(L_BALL_CX);
      r_ball_y       <= COORD_W'(L_BALL_CY);
      r_player_y     <= COORD_W'(L_PAD_C);
      r_opp_y        <= COORD_W'(L_PAD_C);
      r_player_score <= '0;
      r_opp_score    <= '0;
      r_dir_x        <= 1'b1;
      r_dir_y        <= 1'b1;
      r_div          <= '0;
      r_cnt          <= '0;
      r_point_pulse  <= 1'b0;
    end else begin
      r_point_pulse <= 1'b0;
      if (i_frame_tick) begin
        r_div <= w_step ? '0 : r_div + DIV_W'(1);
      end
      if (w_step) begin
        unique case (r_state)
          S_IDLE, S_OVER: begin
            if (i_serve) begin
              r_state        <= S_SERVE;
              r_player_score <= '0;
              r_opp_score    <= '0;
              r_cnt          <= '0;
              r_ball_x       <= COORD_W'(L_BALL_CX);
              r_ball_y       <= COORD_W'(L_BALL_CY);
            end
          end
          S_SERVE: begin
            r_player_y <= w_player_nxt;
            r_opp_y    <= w_opp_nxt;
            r_ball_x   <= COORD_W'(L_BALL_CX);
            r_ball_y   <= COORD_W'(L_BALL_CY);
            if (r_cnt == CNT_W'(SERVE_DELAY - 1)) begin
              r_state <= S_PLAY;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_PLAY: begin
            r_player_y <= w_player_nxt;
            r_opp_y    <= w_opp_nxt;
            if (w_miss_l || w_miss_r) begin
              r_point_pulse <= 1'b1;
              r_ball_x      <= COORD_W'(L_BALL_CX);
              r_ball_y      <= COORD_W'(L_BALL_CY);
              if (w_miss_l) begin
                r_player_score <= w_ps_inc;
                r_dir_x        <= 1'b0;
                r_state        <= (w_ps_inc == SCORE_W'(WIN_SCORE)) ? S_OVER : S_SERVE;
              end else begin
                r_opp_score <= w_os_inc;
                r_dir_x     <= 1'b1;
                r_state     <= (w_os_inc == SCORE_W'(WIN_SCORE)) ? S_OVER : S_SERVE;
              end
            end else begin
              r_ball_x <= w_bx_nxt;
              r_ball_y <= w_by_nxt;
              r_dir_x  <= w_dir_x_nxt;
              r_dir_y  <= w_dir_y_nxt;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_ball_x       = r_ball_x;
  assign o_ball_y       = r_ball_y;
  assign o_player_y     = r_player_y;
  assign o_opp_y        = r_opp_y;
  assign o_player_score = r_player_score;
  assign o_opp_score    = r_opp_score;
  assign o_state        = r_state;
  assign o_point_pulse  = r_point_pulse;

endmodule
